// File: rtl/risc16_mem_pkg.sv
// Shared memory-side types and defaults for the risc16 data path.
package risc16_mem_pkg;

    localparam int WORD_LEN = 16;
    localparam int ADDR_LEN = 16;
    localparam int SB_DEPTH = 4;

    typedef struct packed {
        logic [ADDR_LEN-1:0] addr;
        logic [WORD_LEN-1:0] data;
    } sb_entry_t;

endpackage : risc16_mem_pkg

// File: rtl/mem_store_buffer.sv
// Posted-write store buffer: queues core stores, retires them on non-load
// cycles and forwards the youngest matching queued store to core loads.
module mem_store_buffer
    import risc16_mem_pkg::*;
#(
    parameter int p_WORD_LEN = WORD_LEN,
    parameter int p_ADDR_LEN = ADDR_LEN,
    parameter int p_DEPTH    = SB_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [p_ADDR_LEN-1:0] i_core_addr,
    input  logic [p_WORD_LEN-1:0] i_core_wr_data,
    input  logic                  i_core_wr_en,
    input  logic                  i_core_rd_en,
    output logic [p_WORD_LEN-1:0] o_core_rd_data,
    output logic                  o_core_stall,
    output logic [p_ADDR_LEN-1:0] o_mem_addr,
    output logic [p_WORD_LEN-1:0] o_mem_wr_data,
    output logic                  o_mem_wr_en,
    input  logic [p_WORD_LEN-1:0] i_mem_rd_data,
    output logic                  o_empty
);

    localparam int PW = $clog2(p_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_FULL = CW'(p_DEPTH);

    logic [p_ADDR_LEN-1:0] addr_q [p_DEPTH];
    logic [p_WORD_LEN-1:0] data_q [p_DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic                  drain_s;
    logic                  full_s;
    logic                  stall_s;
    logic                  enq_s;
    logic                  fwd_hit_s;
    logic [p_WORD_LEN-1:0] fwd_data_s;

    // Walk entries oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = {p_WORD_LEN{1'b0}};
        for (int k = 0; k < p_DEPTH; k++) begin
            if ((CW'(k) < count_q) && (addr_q[head_q + PW'(k)] == i_core_addr)) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = data_q[head_q + PW'(k)];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    // Port arbitration: any load request (even the illegal load+store) blocks drain.
    always_comb begin
        drain_s = (count_q != CNT_ZERO) && !i_core_rd_en;
        full_s  = (count_q == CNT_FULL);
        stall_s = i_core_wr_en && full_s && !drain_s;
        enq_s   = i_core_wr_en && !stall_s;

        if (drain_s) begin
            o_mem_addr    = addr_q[head_q];
            o_mem_wr_data = data_q[head_q];
            o_mem_wr_en   = 1'b1;
        end else begin
            o_mem_addr    = i_core_addr;
            o_mem_wr_data = {p_WORD_LEN{1'b0}};
            o_mem_wr_en   = 1'b0;
        end

        if (i_core_rd_en && !i_core_wr_en) begin
            o_core_rd_data = fwd_hit_s ? fwd_data_s : i_mem_rd_data;
        end else begin
            o_core_rd_data = {p_WORD_LEN{1'b0}};
        end

        o_core_stall = stall_s;
        o_empty      = (count_q == CNT_ZERO);
    end

    // Pointer and occupancy next-state.
    always_comb begin
        head_d  = drain_s ? (head_q + PTR_ONE) : head_q;
        tail_d  = enq_s ? (tail_q + PTR_ONE) : tail_q;
        count_d = count_q;
        case ({enq_s, drain_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state; reset drops any queued stores.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= CNT_ZERO;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: validity comes from head/count.
    always_ff @(posedge i_clk) begin
        if (enq_s) begin
            addr_q[tail_q] <= i_core_addr;
            data_q[tail_q] <= i_core_wr_data;
        end
    end

endmodule : mem_store_buffer
